n64adv2_i2s_tx: RTL and testbench
=================================

N64ADV2_I2S_TX -- requirements
Module: n64adv2_i2s_tx

Interface
REQ-001 Parameter SCLK_HALF_DIV, default 4: MCLK cycles per SCLK half-period; legal range 2..16.
REQ-002 MCLK_i  in  1  audio master clock; the only clock; all logic on its rising edge.
REQ-003 RST_i  in  1  reset, synchronous and active-high.
REQ-004 sample_l_i  in  16  left sample, two's complement.
REQ-005 sample_r_i  in  16  right sample, two's complement.
REQ-006 sample_valid_i  in  1  sample pair present.
REQ-007 sample_ready_o  out  1  holding register empty; transfer occurs when valid and ready are both high in the same cycle.
REQ-008 mute_i  in  1  when high at frame load, transmit zeros; the sample is still consumed.
REQ-009 SCLK_o  out  1  I2S bit clock.
REQ-010 LRCLK_o  out  1  word select; 0 = left, 1 = right.
REQ-011 SDATA_o  out  1  serial data, MSB first.
REQ-012 underrun_o  out  1  one-cycle pulse when a frame load finds no sample.

Function
REQ-013 phase_cnt counts 0..SCLK_HALF_DIV-1 and wraps; SCLK_o toggles in the cycle after phase_cnt = SCLK_HALF_DIV-1.
REQ-014 A falling event is the cycle in which SCLK_o goes 1->0.
- On each falling event, the 5-bit slot_cnt increments, wrapping 31->0.
- Slot_cnt changes only on falling events.
REQ-015 LRCLK_o = slot_cnt[4], registered; it changes only together with a falling event.
REQ-016 Data framing uses I2S 1-bit delay, with the 16-bit left sample L and 16-bit right sample R:
- Slots 1..16 carry L[15]..L[0].
- Slots 17..31 carry R[15]..R[1].
- Slot 0 of the following frame carries R[0].
REQ-017 SDATA_o, SCLK_o and LRCLK_o update in the same MCLK cycle, so data is stable across every SCLK rising edge.
REQ-018 Frame load occurs on the falling event where slot_cnt goes 0->1; the 32-bit shift register loads {L,R} from the holding register.
- The holding register then empties.
- sample_ready_o rises on the next cycle.
REQ-019 Bypass: if the holding register is empty and a transfer occurs in the frame-load cycle, the incoming pair loads directly into the shift register.
- No underrun is reported.
- The holding register stays empty.
REQ-020 Underrun: if the holding register is empty at frame load and no bypass applies:
- The shift register loads all zeros.
- underrun_o pulses high for exactly one cycle.
REQ-021 If mute_i = 1 at frame load, the shift register loads zeros, independent of the holding register content; the holding register is still consumed.
REQ-022 sample_ready_o is registered: high whenever the holding register is empty and RST_i is low.
- A transfer sets the register full; sample_ready_o is 0 from the next cycle.
- A transfer with sample_ready_o = 0 is ignored; data is neither captured nor corrupted.
REQ-023 The shift register keeps its R[0] bit through slot 0 of the next frame; the frame load overwrites only the remaining bits.
REQ-024 Frame period = 64 * SCLK_HALF_DIV MCLK cycles (256 at default); no phase drift and no gaps between frames.

Reset
REQ-025 While RST_i is high, the following hold in the cycle after each sampled high:
- SCLK_o, LRCLK_o, SDATA_o, underrun_o and sample_ready_o are 0.
- phase_cnt and slot_cnt are 0.
- The shift register is zero and the holding register is empty.
REQ-026 Reset asserted mid-frame, including with SCLK_o high, takes effect on the next MCLK edge with the REQ-025 values; no partial SCLK pulse completes.
REQ-027 In the first cycle after RST_i falls, sample_ready_o = 1.
- The first SCLK rise occurs SCLK_HALF_DIV cycles after RST_i is released.
- The first frame load occurs 2*SCLK_HALF_DIV cycles after RST_i is released.

Verification
REQ-028 Default divider; after reset, offer L=16'hA5C3, R=16'h0F01 once.
- SDATA_o sampled on SCLK rises, slots 1..31 then next slot 0, reads bits A5C3 followed by 0F01.
- LRCLK_o toggles every 16 SCLK periods.
REQ-029 No sample offered after reset: SDATA_o stays 0, and underrun_o pulses once per 256 MCLK cycles, each coinciding with a 0->1 slot transition.
REQ-030 Valid offered exactly in the frame-load cycle with the holding register empty (bypass): frame carries the sample, underrun_o stays 0, and sample_ready_o stays 1.
REQ-031 Back-to-back stream with valid held high: exactly one transfer per frame, no underrun over 100 frames, and SDATA_o matches the sequence order.
REQ-032 mute_i = 1 during one load with sample 16'h7FFF/16'h8000: that frame transmits all zeros; the next frame transmits the next sample and not the muted one.
REQ-033 RST_i pulsed for 1 cycle while SCLK_o = 1 mid-right-slot:
- Next cycle, all outputs and counters are 0 and the holding register is empty.
- Framing restarts per REQ-027.

Source files
------------

// File: rtl/n64adv2_i2s_tx.sv
// I2S transmitter: 16-bit stereo frames, 32 SCLK periods per frame, 1-bit delayed framing.
// A one-entry holding register accepts sample pairs; frames load on the slot 0->1 SCLK fall.
module n64adv2_i2s_tx #(
    parameter int SCLK_HALF_DIV = 4
) (
    input  logic        MCLK_i,
    input  logic        RST_i,
    input  logic [15:0] sample_l_i,
    input  logic [15:0] sample_r_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    input  logic        mute_i,
    output logic        SCLK_o,
    output logic        LRCLK_o,
    output logic        SDATA_o,
    output logic        underrun_o
);

    localparam int            PW         = $clog2(SCLK_HALF_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_HALF_DIV - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          sclk_q, sclk_d;
    logic [4:0]    slot_q, slot_d;
    logic          lrclk_q, lrclk_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [15:0]   hold_l_q, hold_l_d;
    logic [15:0]   hold_r_q, hold_r_d;
    logic          hold_full_q, hold_full_d;
    logic          ready_q, ready_d;
    logic          underrun_q, underrun_d;

    logic          phase_wrap;
    logic          fall_evt;
    logic          load_evt;
    logic          xfer;
    logic [31:0]   load_word;

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        phase_wrap  = (phase_q == PHASE_LAST);
        fall_evt    = phase_wrap && sclk_q;
        load_evt    = fall_evt && (slot_q == 5'd0);
        xfer        = sample_valid_i && ready_q;

        phase_d     = phase_wrap ? '0 : phase_q + 1'b1;
        sclk_d      = phase_wrap ? ~sclk_q : sclk_q;
        slot_d      = fall_evt ? slot_q + 5'd1 : slot_q;
        lrclk_d     = slot_d[4];

        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        underrun_d  = 1'b0;
        load_word   = '0;

        if (load_evt) begin
            // A full holding register blocks transfers, so bypass only applies when empty.
            if (hold_full_q) begin
                load_word   = {hold_l_q, hold_r_q};
                hold_full_d = 1'b0;
            end else if (xfer) begin
                load_word   = {sample_l_i, sample_r_i};
            end else begin
                underrun_d  = 1'b1;
            end
            if (mute_i) begin
                load_word = '0;
            end
            shreg_d = load_word;
        end else begin
            // R[0] sits in bit 31 during slot 0 and is replaced only by the next load.
            if (fall_evt) begin
                shreg_d = {shreg_q[30:0], 1'b0};
            end
            if (xfer) begin
                hold_l_d    = sample_l_i;
                hold_r_d    = sample_r_i;
                hold_full_d = 1'b1;
            end
        end

        ready_d = ~hold_full_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge MCLK_i) begin
        if (RST_i) begin
            phase_q     <= '0;
            sclk_q      <= 1'b0;
            slot_q      <= 5'd0;
            lrclk_q     <= 1'b0;
            shreg_q     <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            sclk_q      <= sclk_d;
            slot_q      <= slot_d;
            lrclk_q     <= lrclk_d;
            shreg_q     <= shreg_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
        end
    end

    // NOTE: the holding data needs no reset; hold_full_q alone says whether it is meaningful.
    always_ff @(posedge MCLK_i) begin
        hold_l_q <= hold_l_d;
        hold_r_q <= hold_r_d;
    end

    assign SCLK_o         = sclk_q;
    assign LRCLK_o        = lrclk_q;
    assign SDATA_o        = shreg_q[31];
    assign underrun_o     = underrun_q;
    assign sample_ready_o = ready_q;

endmodule

// File: tb/tb_n64adv2_i2s_tx.sv
// Self-checking bench for n64adv2_i2s_tx: stimulus queues expected frames, a monitor
// reassembles frames from SDATA on SCLK rises and compares them against the queue.
module tb_n64adv2_i2s_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 64 * DIV;

    typedef struct packed {
        logic [31:0] data;
        logic        ur;
    } exp_t;

    logic        MCLK_i = 1'b0;
    logic        RST_i  = 1'b1;
    logic [15:0] sample_l_i = '0;
    logic [15:0] sample_r_i = '0;
    logic        sample_valid_i = 1'b0;
    logic        sample_ready_o;
    logic        mute_i = 1'b0;
    logic        SCLK_o;
    logic        LRCLK_o;
    logic        SDATA_o;
    logic        underrun_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    n64adv2_i2s_tx #(.SCLK_HALF_DIV(DIV)) dut (
        .MCLK_i         (MCLK_i),
        .RST_i          (RST_i),
        .sample_l_i     (sample_l_i),
        .sample_r_i     (sample_r_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .mute_i         (mute_i),
        .SCLK_o         (SCLK_o),
        .LRCLK_o        (LRCLK_o),
        .SDATA_o        (SDATA_o),
        .underrun_o     (underrun_o)
    );

    always #5 MCLK_i = ~MCLK_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge MCLK_i);
    endtask

    task automatic push_exp(input logic [31:0] data, input logic ur);
        exp_t e;
        e.data = data;
        e.ur   = ur;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] seq_word(input int i);
        logic [15:0] l;
        logic [15:0] r;
        l = 16'h5A00 ^ 16'(i * 257);
        r = 16'hFFFF - 16'(i * 3);
        return {l, r};
    endfunction

    // Two reset cycles, reset-state checks, then release; returns at the release negedge.
    task automatic do_reset();
        sample_valid_i = 1'b0;
        mute_i         = 1'b0;
        RST_i          = 1'b1;
        step(2);
        check("rst_sclk",     32'(SCLK_o), 0);
        check("rst_lrclk",    32'(LRCLK_o), 0);
        check("rst_sdata",    32'(SDATA_o), 0);
        check("rst_underrun", 32'(underrun_o), 0);
        check("rst_ready",    32'(sample_ready_o), 0);
        sb_q.delete();
        RST_i = 1'b0;
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        logic rdy;
        int   n;
        n              = 0;
        sample_l_i     = l;
        sample_r_i     = r;
        sample_valid_i = 1'b1;
        do begin
            rdy = sample_ready_o;
            @(negedge MCLK_i);
            n++;
        end while (!rdy && n < 1000);
        sample_valid_i = 1'b0;
        check("offer_accepted", 32'(rdy), 1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge MCLK_i);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    // Monitor: samples just after each rising MCLK edge.
    int          cyc, rise_cnt, fall_cnt, n_loads, last_load, slot;
    logic        prev_sclk, load_ur;
    logic [31:0] word, lrw;
    exp_t        got_e;

    always begin
        @(posedge MCLK_i);
        #1;
        if (RST_i) begin
            cyc       = 0;
            rise_cnt  = 0;
            fall_cnt  = 0;
            n_loads   = 0;
            last_load = 0;
            prev_sclk = 1'b0;
            load_ur   = 1'b0;
            word      = '0;
            lrw       = '0;
        end else begin
            cyc++;
            if (prev_sclk && !SCLK_o && ((fall_cnt + 1) % 32 == 1)) begin
                fall_cnt++;
                load_ur = underrun_o;
                if (n_loads == 0) check("first_load_cycle", cyc, 2 * DIV);
                else check("frame_period", cyc - last_load, FRAME);
                n_loads++;
                last_load = cyc;
            end else begin
                if (prev_sclk && !SCLK_o) fall_cnt++;
                if (underrun_o) check("underrun_stray", 32'(underrun_o), 0);
            end
            if (!prev_sclk && SCLK_o) begin
                rise_cnt++;
                slot = (rise_cnt - 1) % 32;
                if (slot == 1) begin
                    word = {31'b0, SDATA_o};
                    lrw  = {31'b0, LRCLK_o};
                end else begin
                    word = {word[30:0], SDATA_o};
                    lrw  = {lrw[30:0], LRCLK_o};
                end
                if (slot == 0 && rise_cnt >= 33) begin
                    if (sb_q.size() == 0) begin
                        check("frame_unexpected", sb_q.size(), 1);
                    end else begin
                        got_e = sb_q.pop_front();
                        check("frame_data", word, got_e.data);
                        check("frame_lrclk", lrw, 32'h0001_FFFE);
                        check("frame_underrun", 32'(load_ur), 32'(got_e.ur));
                    end
                end
            end
            prev_sclk = SCLK_o;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   i, e, last_edge;
        logic rdy;
        logic [31:0] w;

        // Single sample A5C3/0F01, release timing, ignored transfer while full.
        do_reset();
        step(1);
        check("rel_ready",  32'(sample_ready_o), 1);
        check("rel_sclk",   32'(SCLK_o), 0);
        step(DIV - 2);
        check("sclk_before_rise", 32'(SCLK_o), 0);
        step(1);
        check("sclk_first_rise",  32'(SCLK_o), 1);
        offer(16'hA5C3, 16'h0F01);
        check("ready_low_full", 32'(sample_ready_o), 0);
        sample_l_i     = 16'hFFFF;
        sample_r_i     = 16'hFFFF;
        sample_valid_i = 1'b1;
        step(2);
        sample_valid_i = 1'b0;
        push_exp(32'hA5C3_0F01, 1'b0);
        push_exp(32'h0000_0000, 1'b1);
        push_exp(32'h0000_0000, 1'b1);
        drain(4 * FRAME);

        // No sample: zeros and one underrun per frame.
        do_reset();
        step(2 * DIV - 1);
        check("sclk_high_before_load", 32'(SCLK_o), 1);
        step(1);
        check("load_sclk_fall",  32'(SCLK_o), 0);
        check("load_underrun",   32'(underrun_o), 1);
        check("load_lrclk",      32'(LRCLK_o), 0);
        step(1);
        check("underrun_width",  32'(underrun_o), 0);
        push_exp(32'h0, 1'b1);
        push_exp(32'h0, 1'b1);
        push_exp(32'h0, 1'b1);
        drain(4 * FRAME);

        // Bypass: transfer exactly in the frame-load cycle.
        do_reset();
        step(2 * DIV - 1);
        sample_l_i     = 16'h1234;
        sample_r_i     = 16'h8001;
        sample_valid_i = 1'b1;
        step(1);
        sample_valid_i = 1'b0;
        check("bypass_ready",    32'(sample_ready_o), 1);
        check("bypass_underrun", 32'(underrun_o), 0);
        step(1);
        check("bypass_ready_next", 32'(sample_ready_o), 1);
        push_exp(32'h1234_8001, 1'b0);
        drain(3 * FRAME);

        // Mute at load: muted frame is zeros, next frame carries the next sample.
        do_reset();
        step(4);
        offer(16'h7FFF, 16'h8000);
        step(2);
        mute_i = 1'b1;
        step(1);
        mute_i = 1'b0;
        check("mute_consumed_ready", 32'(sample_ready_o), 1);
        check("mute_underrun",       32'(underrun_o), 0);
        offer(16'h1357, 16'h2468);
        push_exp(32'h0000_0000, 1'b0);
        push_exp(32'h1357_2468, 1'b0);
        drain(3 * FRAME);

        // Back-to-back stream with valid held high for 101 frames.
        do_reset();
        i         = 0;
        e         = 0;
        last_edge = 0;
        w         = seq_word(0);
        sample_l_i     = w[31:16];
        sample_r_i     = w[15:0];
        sample_valid_i = 1'b1;
        while (i < 101 && e < 30000) begin
            rdy = sample_ready_o;
            @(negedge MCLK_i);
            e++;
            if (rdy) begin
                push_exp(seq_word(i), 1'b0);
                i++;
                last_edge  = e;
                w          = seq_word(i);
                sample_l_i = w[31:16];
                sample_r_i = w[15:0];
            end
        end
        sample_valid_i = 1'b0;
        check("b2b_count", i, 101);
        check("b2b_last_edge", last_edge, 9 + FRAME * 99);
        drain(4 * FRAME);

        // One-cycle reset while SCLK is high in the right slot.
        do_reset();
        step(4);
        offer(16'hCAFE, 16'hBEEF);
        step(160);
        check("mid_sclk",  32'(SCLK_o), 1);
        check("mid_lrclk", 32'(LRCLK_o), 1);
        check("mid_sdata", 32'(SDATA_o), 1);
        RST_i = 1'b1;
        step(1);
        check("pulse_sclk",     32'(SCLK_o), 0);
        check("pulse_lrclk",    32'(LRCLK_o), 0);
        check("pulse_sdata",    32'(SDATA_o), 0);
        check("pulse_underrun", 32'(underrun_o), 0);
        check("pulse_ready",    32'(sample_ready_o), 0);
        RST_i = 1'b0;
        sb_q.delete();
        step(1);
        check("pulse_rel_ready", 32'(sample_ready_o), 1);
        step(DIV - 2);
        check("pulse_sclk_low",  32'(SCLK_o), 0);
        step(1);
        check("pulse_sclk_rise", 32'(SCLK_o), 1);
        push_exp(32'h0, 1'b1);
        drain(3 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
